scan_req_ctrl: RTL and testbench

- Upstream stage of the scan memory/register interface.
- Deserialises an externally driven scan chain into a 50-bit command word `{op[1:0], addr[15:0], data[31:0]}`.
- Issues one read or write request on the `scan_ren`/`scan_wen`/`scan_addr`/`scan_wdata` bus that feeds the SRAM/register mux, then waits for `scan_ready`.
- Loads the returned `scan_rdata` back into the chain so it can be shifted out on `scan_out`.

---
 rtl/scan_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/scan_req_ctrl.sv | 132 +++++++++++++
 tb/tb_scan_req_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the scan request controller: command word layout,
// op encodings and controller states.
package scan_pkg;

  localparam int CHAIN_W  = 50;

  localparam int OP_MSB   = 49;
  localparam int OP_LSB   = 48;
  localparam int ADDR_MSB = 47;
  localparam int ADDR_LSB = 32;
  localparam int DATA_MSB = 31;
  localparam int DATA_LSB = 0;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_REQ
  } scan_state_t;

  // 2'b00 and 2'b11 are both treated as NOP
  function automatic logic is_valid_op(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pin, reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/scan_req_ctrl.sv
// Scan chain front end: shifts in a {op, addr, data} command, issues one bus
// request to the SRAM/register mux and loads read data back into the chain.
module scan_req_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CHAIN_W = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_tck,
  input  logic        scan_en,
  input  logic        scan_in,
  input  logic        scan_update,
  output logic        scan_out,
  output logic        scan_ren,
  output logic        scan_wen,
  output logic [15:0] scan_addr,
  output logic [31:0] scan_wdata,
  input  logic [31:0] scan_rdata,
  input  logic        scan_ready,
  output logic        busy,
  output logic        err
);

  import scan_pkg::*;

  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  scan_state_t        state;
  scan_state_t        next_state;
  logic [CHAIN_W-1:0] chain;
  logic [1:0]         op_q;
  logic [1:0]         req_op;
  logic [CNT_W-1:0]   cnt;

  logic tck_s, en_s, in_s, upd_s;
  logic tck_d, upd_d;
  logic tck_rise, upd_rise;
  logic do_shift, launch, req_done, req_timeout;
  logic ren_d, wen_d;

  sync_2ff u_sync_tck (.clk(clk), .rst(rst), .d(scan_tck),    .q(tck_s));
  sync_2ff u_sync_en  (.clk(clk), .rst(rst), .d(scan_en),     .q(en_s));
  sync_2ff u_sync_in  (.clk(clk), .rst(rst), .d(scan_in),     .q(in_s));
  sync_2ff u_sync_upd (.clk(clk), .rst(rst), .d(scan_update), .q(upd_s));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tck_d <= 1'b0;
      upd_d <= 1'b0;
    end else begin
      tck_d <= tck_s;
      upd_d <= upd_s;
    end
  end

  assign tck_rise = tck_s & ~tck_d;
  assign upd_rise = upd_s & ~upd_d;

  // A shift edge wins over a coincident launch; edges seen in REQ are dropped
  assign do_shift    = (state == ST_IDLE) && tck_rise && en_s;
  assign launch      = (state == ST_IDLE) && upd_rise && !tck_rise &&
                       is_valid_op(chain[OP_MSB:OP_LSB]);
  assign req_done    = (state == ST_REQ) && scan_ready;
  assign req_timeout = (state == ST_REQ) && !scan_ready && (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (launch) next_state = ST_REQ;
      ST_REQ:  if (req_done || req_timeout) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Request strobes are precomputed from next_state so the registered copies
  // rise the cycle after launch and fall the cycle after completion
  always_comb begin
    req_op = (state == ST_IDLE) ? chain[OP_MSB:OP_LSB] : op_q;
    ren_d  = (next_state == ST_REQ) && (req_op == OP_READ);
    wen_d  = (next_state == ST_REQ) && (req_op == OP_WRITE);
    busy   = (state == ST_REQ);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_ren <= 1'b0;
      scan_wen <= 1'b0;
    end else begin
      scan_ren <= ren_d;
      scan_wen <= wen_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain      <= '0;
      op_q       <= OP_NOP;
      scan_addr  <= '0;
      scan_wdata <= '0;
      cnt        <= '0;
      err        <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (do_shift) begin
        chain <= {in_s, chain[CHAIN_W-1:1]};
      end else if (launch) begin
        op_q       <= chain[OP_MSB:OP_LSB];
        scan_addr  <= chain[ADDR_MSB:ADDR_LSB];
        scan_wdata <= chain[DATA_MSB:DATA_LSB];
        cnt        <= '0;
        err        <= 1'b0;
      end
    end else begin
      if (req_done) begin
        if (op_q == OP_READ) chain[DATA_MSB:DATA_LSB] <= scan_rdata;
      end else if (req_timeout) begin
        chain[DATA_MSB:DATA_LSB] <= 32'h0;
        err                      <= 1'b1;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign scan_out = chain[0];

endmodule

// File: tb/tb_scan_req_ctrl.sv
// Directed bench for scan_req_ctrl: table of shift/launch/respond vectors plus
// hand-written timeout, ignore-during-REQ and reset-mid-REQ sequences.
module tb_scan_req_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_tck = 1'b0;
  logic        scan_en = 1'b0;
  logic        scan_in = 1'b0;
  logic        scan_update = 1'b0;
  logic        scan_out;
  logic        scan_ren;
  logic        scan_wen;
  logic [15:0] scan_addr;
  logic [31:0] scan_wdata;
  logic [31:0] scan_rdata = 32'h0;
  logic        scan_ready = 1'b0;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;
  int ren_cnt = 0;
  int wen_cnt = 0;
  int busy_cnt = 0;

  scan_req_ctrl #(.TIMEOUT(255), .CHAIN_W(50)) dut (
    .clk(clk), .rst(rst),
    .scan_tck(scan_tck), .scan_en(scan_en), .scan_in(scan_in),
    .scan_update(scan_update), .scan_out(scan_out),
    .scan_ren(scan_ren), .scan_wen(scan_wen),
    .scan_addr(scan_addr), .scan_wdata(scan_wdata),
    .scan_rdata(scan_rdata), .scan_ready(scan_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (scan_ren) ren_cnt++;
    if (scan_wen) wen_cnt++;
    if (busy)     busy_cnt++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [31:0] data;
    int          ready_delay;
    logic [31:0] rdata;
    int          exp_ren;
    int          exp_wen;
    logic [49:0] exp_chain;
  } vec_t;

  vec_t vecs[6];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    ren_cnt = 0;
    wen_cnt = 0;
    busy_cnt = 0;
  endtask

  // Each tck phase is held 4 clk cycles so the synchronised edge lands cleanly
  task automatic shift_bit(input logic b);
    scan_en = 1'b1;
    scan_in = b;
    repeat (4) @(negedge clk);
    scan_tck = 1'b1;
    repeat (4) @(negedge clk);
    scan_tck = 1'b0;
  endtask

  task automatic shift_word(input logic [49:0] w);
    for (int i = 0; i < 50; i++) shift_bit(w[i]);
    scan_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic read_chain(output logic [49:0] r);
    r = '0;
    for (int i = 0; i < 50; i++) begin
      r[i] = scan_out;
      shift_bit(1'b0);
    end
    scan_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Mux model: raises ready in the delay-th request cycle (0 = never)
  task automatic apply_stimulus(input int delay, input logic [31:0] rd,
                                output logic stable, output logic [15:0] a,
                                output logic [31:0] wd);
    int k;
    int w;
    stable = 1'b1;
    a = '0;
    wd = '0;
    w = 0;
    while (!(scan_ren || scan_wen) && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (scan_ren || scan_wen) begin
      a = scan_addr;
      wd = scan_wdata;
      k = 0;
      while ((scan_ren || scan_wen) && k < 400) begin
        k++;
        if (scan_addr !== a || scan_wdata !== wd) stable = 1'b0;
        if (k == delay) begin
          scan_ready = 1'b1;
          scan_rdata = rd;
        end
        @(negedge clk);
        scan_ready = 1'b0;
        scan_rdata = 32'h0;
      end
    end
  endtask

  task automatic launch_and_serve(input logic [49:0] w, input int delay, input logic [31:0] rd,
                                  output logic stable, output logic [15:0] a,
                                  output logic [31:0] wd);
    shift_word(w);
    clear_counts();
    scan_update = 1'b1;
    apply_stimulus(delay, rd, stable, a, wd);
    repeat (6) @(negedge clk);
    scan_update = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    logic [49:0] got;
    logic        stable;
    logic [15:0] a;
    logic [31:0] wd;
    int          w;

    vecs[0] = '{2'b10, 16'h8000, 32'hA5A5_1234, 2, 32'h0,         0, 2, {2'b10, 16'h8000, 32'hA5A5_1234}};
    vecs[1] = '{2'b01, 16'h0010, 32'h0000_0000, 1, 32'hCAFE_F00D, 1, 0, {2'b01, 16'h0010, 32'hCAFE_F00D}};
    vecs[2] = '{2'b00, 16'h1234, 32'h5555_5555, 1, 32'h0,         0, 0, {2'b00, 16'h1234, 32'h5555_5555}};
    vecs[3] = '{2'b11, 16'hBEEF, 32'h0F0F_0F0F, 1, 32'h0,         0, 0, {2'b11, 16'hBEEF, 32'h0F0F_0F0F}};
    vecs[4] = '{2'b01, 16'hFFFF, 32'h1234_5678, 3, 32'h0F0F_0F0F, 3, 0, {2'b01, 16'hFFFF, 32'h0F0F_0F0F}};
    vecs[5] = '{2'b10, 16'h0000, 32'hFFFF_FFFF, 1, 32'h0,         0, 1, {2'b10, 16'h0000, 32'hFFFF_FFFF}};

    repeat (3) @(negedge clk);
    check_output("reset_ren",   scan_ren, 0);
    check_output("reset_wen",   scan_wen, 0);
    check_output("reset_busy",  busy, 0);
    check_output("reset_err",   err, 0);
    check_output("reset_addr",  scan_addr, 0);
    check_output("reset_wdata", scan_wdata, 0);
    check_output("reset_out",   scan_out, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      launch_and_serve({vecs[i].op, vecs[i].addr, vecs[i].data}, vecs[i].ready_delay,
                       vecs[i].rdata, stable, a, wd);
      check_output($sformatf("v%0d_ren_cycles", i), 64'(ren_cnt), 64'(vecs[i].exp_ren));
      check_output($sformatf("v%0d_wen_cycles", i), 64'(wen_cnt), 64'(vecs[i].exp_wen));
      check_output($sformatf("v%0d_busy_cycles", i), 64'(busy_cnt),
                   64'(vecs[i].exp_ren + vecs[i].exp_wen));
      check_output($sformatf("v%0d_err", i), err, 0);
      if (vecs[i].exp_ren + vecs[i].exp_wen > 0) begin
        check_output($sformatf("v%0d_addr", i), a, vecs[i].addr);
        check_output($sformatf("v%0d_wdata", i), wd, vecs[i].data);
        check_output($sformatf("v%0d_stable", i), stable, 1);
      end
      read_chain(got);
      check_output($sformatf("v%0d_chain", i), got, vecs[i].exp_chain);
    end

    // Timeout: read never answered
    launch_and_serve({2'b01, 16'h0042, 32'hDEAD_BEEF}, 0, 32'h0, stable, a, wd);
    check_output("to_ren_cycles", 64'(ren_cnt), 256);
    check_output("to_wen_cycles", 64'(wen_cnt), 0);
    check_output("to_err", err, 1);
    read_chain(got);
    check_output("to_chain", got, {2'b01, 16'h0042, 32'h0});

    launch_and_serve({2'b00, 16'h0042, 32'h1111_2222}, 1, 32'h0, stable, a, wd);
    check_output("to_nop_keeps_err", err, 1);
    check_output("to_nop_no_req", 64'(ren_cnt + wen_cnt), 0);
    launch_and_serve({2'b10, 16'h0777, 32'h7777_0000}, 1, 32'h0, stable, a, wd);
    check_output("to_relaunch_err", err, 0);
    check_output("to_relaunch_wen", 64'(wen_cnt), 1);
    read_chain(got);

    // Shift edges and a second update arriving while REQ is pending
    shift_word({2'b01, 16'h00AA, 32'h1111_1111});
    clear_counts();
    scan_update = 1'b1;
    w = 0;
    while (!scan_ren && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_output("ign_req_started", scan_ren, 1);
    for (int i = 0; i < 3; i++) shift_bit(1'b1);
    scan_en = 1'b0;
    scan_update = 1'b0;
    repeat (4) @(negedge clk);
    scan_update = 1'b1;
    repeat (4) @(negedge clk);
    check_output("ign_still_busy", busy, 1);
    check_output("ign_addr", scan_addr, 16'h00AA);
    scan_ready = 1'b1;
    scan_rdata = 32'h2222_2222;
    @(negedge clk);
    scan_ready = 1'b0;
    scan_rdata = 32'h0;
    check_output("ign_ren_drop", scan_ren, 0);
    clear_counts();
    repeat (20) @(negedge clk);
    scan_update = 1'b0;
    repeat (20) @(negedge clk);
    check_output("ign_no_second_req", 64'(ren_cnt + wen_cnt), 0);
    read_chain(got);
    check_output("ign_chain", got, {2'b01, 16'h00AA, 32'h2222_2222});

    // Reset asserted in the middle of a read request
    shift_word({2'b01, 16'h0100, 32'h3333_3333});
    scan_update = 1'b1;
    w = 0;
    while (!scan_ren && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_output("rst_req_started", scan_ren, 1);
    rst = 1'b1;
    scan_update = 1'b0;
    #1;
    check_output("rst_ren", scan_ren, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_out", scan_out, 0);
    check_output("rst_addr", scan_addr, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    clear_counts();
    scan_ready = 1'b1;
    scan_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    scan_ready = 1'b0;
    scan_rdata = 32'h0;
    repeat (20) @(negedge clk);
    check_output("rst_no_activity", 64'(ren_cnt + wen_cnt + busy_cnt), 0);
    read_chain(got);
    check_output("rst_chain", got, 50'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
